// File: rtl/demod_pkg.sv
// Shared types and widths for the demodulator sequencing controller.
package demod_pkg;

    localparam int SAMPLE_W = 32;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4
    } demod_state_t;

    // Byte idx of a word, counted from the MSB (idx 0 = bits [31:24]).
    function automatic logic [BYTE_W-1:0] msb_byte(input logic [SAMPLE_W-1:0] word,
                                                   input logic [1:0]          idx);
        logic [SAMPLE_W-1:0] shifted;
        shifted = word << (BYTE_W * idx);
        return shifted[SAMPLE_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/demod_byte_collector.sv
// Assembles UART bytes into 32-bit samples and holds one pending sample.
// DEMOD_SEQ_TIMEOUT_EN adds the partial-word timeout that drives resync.
module demod_byte_collector
    import demod_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid_i,
    input  logic [BYTE_W-1:0]   rx_data_i,
    input  logic                pend_clr,
    output logic [SAMPLE_W-1:0] pend_word,
    output logic                pend_v,
    output logic                overrun,
    output logic                resync
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("demod_byte_collector: TIMEOUT must be 1..65535");
    end

    logic [1:0]                 byte_cnt;
    logic [SAMPLE_W-BYTE_W-1:0] shift_q;
    logic                       word_done;
    logic [SAMPLE_W-1:0]        word;
    logic                       timeout_hit;

    assign word_done = rx_valid_i && (byte_cnt == 2'd3);
    assign word      = {shift_q, rx_data_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            shift_q   <= '0;
            pend_word <= '0;
            pend_v    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_valid_i) begin
                shift_q  <= word[SAMPLE_W-BYTE_W-1:0];
                byte_cnt <= byte_cnt + 2'd1;
            end else if (timeout_hit) begin
                byte_cnt <= '0;
            end
            // A word landing in the same cycle the FSM consumes the pending one is kept.
            if (word_done) begin
                if (pend_v && !pend_clr) begin
                    overrun <= 1'b1;
                end else begin
                    pend_word <= word;
                    pend_v    <= 1'b1;
                end
            end else if (pend_clr) begin
                pend_v <= 1'b0;
            end
        end
    end

`ifdef DEMOD_SEQ_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = !rx_valid_i && (byte_cnt != 2'd0) && (idle_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            resync   <= 1'b0;
        end else begin
            if (rx_valid_i || byte_cnt == 2'd0 || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (timeout_hit) begin
                resync <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resync      = 1'b0;
`endif

endmodule

// File: rtl/demod_seq_ctrl.sv
// Sequencing controller: issues assembled samples to the datapath and serialises results.
// Optional partial-word timeout is enabled with DEMOD_SEQ_TIMEOUT_EN.
module demod_seq_ctrl
    import demod_pkg::*;
#(
    parameter int PIPE_LAT  = 4,
    parameter int OUT_BYTES = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid_i,
    input  logic [BYTE_W-1:0]   rx_data_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                issue_o,
    input  logic [SAMPLE_W-1:0] result_i,
    output logic [BYTE_W-1:0]   tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                resync_o
);

    if (PIPE_LAT < 1 || PIPE_LAT > 255 || OUT_BYTES < 1 || OUT_BYTES > 4) begin : g_bad_param
        $error("demod_seq_ctrl: PIPE_LAT must be 1..255 and OUT_BYTES 1..4");
    end

    demod_state_t        state, state_nxt;
    logic [7:0]          lat_cnt;
    logic [1:0]          byte_idx;
    logic [SAMPLE_W-1:0] result_p0;
    logic [SAMPLE_W-1:0] pend_word;
    logic                pend_v;
    logic                pend_clr;
    logic                last_byte;

    assign pend_clr  = (state == ST_ISSUE);
    assign last_byte = (byte_idx == 2'(OUT_BYTES - 1));

    demod_byte_collector #(
        .TIMEOUT (TIMEOUT)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .pend_clr   (pend_clr),
        .pend_word  (pend_word),
        .pend_v     (pend_v),
        .overrun    (overrun_o),
        .resync     (resync_o)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pend_v) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = (PIPE_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT:    if (lat_cnt == 8'd1) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_SEND;
            ST_SEND: begin
                if (tx_ready_i && last_byte) begin
                    state_nxt = pend_v ? ST_ISSUE : ST_IDLE;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            byte_idx  <= '0;
            result_p0 <= '0;
            sample_o  <= '0;
        end else begin
            state <= state_nxt;
            // Sample is presented to the datapath for the whole ISSUE cycle and held after.
            if (state_nxt == ST_ISSUE) begin
                sample_o <= pend_word;
            end
            case (state)
                ST_ISSUE: lat_cnt <= 8'(PIPE_LAT - 1);
                ST_WAIT:  lat_cnt <= lat_cnt - 8'd1;
                // ---- datapath result -> result_p0 ----
                ST_CAPTURE: begin
                    result_p0 <= result_i;
                    byte_idx  <= '0;
                end
                ST_SEND:  if (tx_ready_i) byte_idx <= byte_idx + 2'd1;
                default:  ;
            endcase
        end
    end

    // ---- result_p0 -> UART byte stream ----
    assign issue_o    = (state == ST_ISSUE);
    assign tx_valid_o = (state == ST_SEND);
    assign tx_data_o  = tx_valid_o ? msb_byte(result_p0, byte_idx) : '0;
    assign busy_o     = (state != ST_IDLE);

endmodule
